// File: rtl/sdram_pkg.sv
// sdram_pkg: command encodings, sequencer states and mode-register fields shared by the SDRAM init/refresh block
package sdram_pkg;
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;
    localparam logic [3:0] CMD_INH = 4'b1111;
    localparam logic [2:0] MR_BL1 = 3'b000;
    localparam logic [2:0] MR_CL2 = 3'b010;
    localparam logic MR_SEQ = 1'b0;
    localparam logic MR_WB_PROG = 1'b0;
    localparam logic [12:0] MODE_DEFAULT = {3'b000, MR_WB_PROG, 2'b00, MR_CL2, MR_SEQ, MR_BL1};
    typedef enum logic [3:0] {PWRUP, PRE, WRP, IREF, WRFC, LMR, WMRD, IDLE, RREF, RWAIT} state_t;
    function automatic int imax(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/sdram_delay_counter.sv
// sdram_delay_counter: loadable down-counter that stops at zero
// Ports: clk/rst clock and async active-high reset; load/din parallel load; value current count; zero flag
module sdram_delay_counter #(
    parameter int W = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    output logic [W-1:0] value,
    output logic         zero
);
    assign zero = value == '0;
    always_ff @(posedge clk or posedge rst)
        if (rst) value <= RST_VAL;
        else if (load) value <= din;
        else if (!zero) value <= value - 1'b1;
endmodule

// File: rtl/sdram_init_refresh.sv
// sdram_init_refresh: JEDEC power-up sequencer and periodic auto-refresh owner of the SDRAM command bus
// Ports: clock_50mhz/pin_reset clock and async active-high reset; ref_gnt controller grant;
//        init_done, ref_req, ref_done, ref_late status; bus_own command-mux select;
//        cke, cs_n, ras_n, cas_n, we_n, ba, addr registered SDRAM command outputs
module sdram_init_refresh
    import sdram_pkg::*;
#(
    parameter int CLK_MHZ = 50,
    parameter int POWERUP_US = 200,
    parameter int T_RP = 2,
    parameter int T_RFC = 4,
    parameter int T_MRD = 2,
    parameter int INIT_REFRESH = 8,
    parameter int REFRESH_PERIOD = 390,
    parameter logic [12:0] MODE_REG = MODE_DEFAULT
) (
    input  logic        clock_50mhz,
    input  logic        pin_reset,
    input  logic        ref_gnt,
    output logic        init_done,
    output logic        ref_req,
    output logic        ref_done,
    output logic        ref_late,
    output logic        bus_own,
    output logic        cke,
    output logic        cs_n,
    output logic        ras_n,
    output logic        cas_n,
    output logic        we_n,
    output logic [1:0]  ba,
    output logic [12:0] addr
);
    localparam int POWERUP_CYC = POWERUP_US * CLK_MHZ;
    localparam int DW = $clog2(imax(POWERUP_CYC, imax(T_RP, imax(T_RFC, T_MRD))) + 1);
    localparam int TW = $clog2(imax(REFRESH_PERIOD, 2));
    localparam int RW = $clog2(imax(INIT_REFRESH, 2));
    // a wait state lasts T-1 cycles, so its counter is loaded with T-2
    localparam logic [DW-1:0] RP_LD = DW'(imax(T_RP - 2, 0));
    localparam logic [DW-1:0] RFC_LD = DW'(imax(T_RFC - 2, 0));
    localparam logic [DW-1:0] MRD_LD = DW'(imax(T_MRD - 2, 0));
    state_t state, nxt;
    logic ld, dz, rdec, fin, wrap;
    logic [DW-1:0] ld_val, dly_value_unused;
    logic [RW-1:0] rcnt;
    logic [TW-1:0] tmr;
    // the reset period is not a counted cycle, so power-up starts one above POWERUP_CYC-1
    sdram_delay_counter #(.W(DW), .RST_VAL(DW'(POWERUP_CYC))) u_dly (
        .clk(clock_50mhz),
        .rst(pin_reset),
        .load(ld),
        .din(ld_val),
        .value(dly_value_unused),
        .zero(dz)
    );
    always_ff @(posedge clock_50mhz or posedge pin_reset)
        if (pin_reset) state <= PWRUP;
        else state <= nxt;
    always_comb begin
        nxt = state;
        ld = 1'b0;
        ld_val = '0;
        rdec = 1'b0;
        fin = 1'b0;
        case (state)
            PWRUP: nxt = dz ? PRE : PWRUP;
            PRE: begin
                nxt = T_RP > 1 ? WRP : IREF;
                ld = 1'b1;
                ld_val = RP_LD;
            end
            WRP: nxt = dz ? IREF : WRP;
            IREF, WRFC: begin
                // rcnt holds the refreshes still owed after the current one
                if (state == WRFC ? dz : T_RFC == 1) begin
                    nxt = rcnt == '0 ? LMR : IREF;
                    rdec = rcnt != '0;
                end else if (state == IREF) begin
                    nxt = WRFC;
                    ld = 1'b1;
                    ld_val = RFC_LD;
                end
            end
            LMR: begin
                nxt = T_MRD > 1 ? WMRD : IDLE;
                ld = 1'b1;
                ld_val = MRD_LD;
            end
            WMRD: nxt = dz ? IDLE : WMRD;
            IDLE: nxt = ref_req && ref_gnt ? RREF : IDLE;
            RREF: begin
                nxt = T_RFC > 1 ? RWAIT : IDLE;
                fin = T_RFC == 1;
                ld = 1'b1;
                ld_val = RFC_LD;
            end
            RWAIT: begin
                nxt = dz ? IDLE : RWAIT;
                fin = dz;
            end
            default: nxt = PWRUP;
        endcase
    end
    assign wrap = init_done && tmr == TW'(REFRESH_PERIOD - 1);
    // outputs are registered from the next state so each command appears in the cycle its state occupies
    always_ff @(posedge clock_50mhz or posedge pin_reset)
        if (pin_reset) begin
            cke <= 1'b0;
            {cs_n, ras_n, cas_n, we_n} <= CMD_INH;
            ba <= '0;
            addr <= '0;
            init_done <= 1'b0;
            ref_req <= 1'b0;
            ref_done <= 1'b0;
            ref_late <= 1'b0;
            bus_own <= 1'b1;
            rcnt <= RW'(INIT_REFRESH - 1);
            tmr <= '0;
        end else begin
            cke <= 1'b1;
            {cs_n, ras_n, cas_n, we_n} <= nxt == PRE ? CMD_PRE :
                (nxt == IREF || nxt == RREF) ? CMD_REF : nxt == LMR ? CMD_LMR : CMD_NOP;
            ba <= '0;
            addr <= nxt == PRE ? 13'h0400 : nxt == LMR ? MODE_REG : 13'h0000;
            init_done <= init_done || nxt == IDLE;
            bus_own <= nxt != IDLE;
            ref_done <= fin;
            ref_req <= (ref_req && !fin) || (wrap && !ref_req);
            ref_late <= ref_late || (wrap && ref_req);
            if (rdec) rcnt <= rcnt - 1'b1;
            if (init_done) tmr <= wrap ? '0 : tmr + 1'b1;
        end
endmodule

// File: tb/tb_sdram_init_refresh.sv
// tb_sdram_init_refresh: scoreboard bench for the SDRAM init/refresh sequencer
module tb_sdram_init_refresh;
    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] PREC = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;
    localparam logic [3:0] LMOD = 4'b0000;
    localparam int TRP = 2, TRFC = 3, TMRD = 2;
    typedef struct {
        int cyc;
        logic done;
        logic [3:0] cmd;
        logic own;
        logic [12:0] addr;
        logic [12:0] mask;
    } evt_t;
    logic clk = 1'b0, rst, gnt;
    logic init_done, ref_req, ref_done, ref_late, bus_own, cke, cs_n, ras_n, cas_n, we_n;
    logic [1:0] ba;
    logic [12:0] addr;
    logic [3:0] mcmd, last_cmd;
    int cyc, last_cyc, checks = 0, fails = 0, gap;
    evt_t sb[$];
    evt_t e;
    always #5 clk = ~clk;
    sdram_init_refresh #(
        .CLK_MHZ(1), .POWERUP_US(10), .T_RP(TRP), .T_RFC(TRFC), .T_MRD(TMRD),
        .INIT_REFRESH(2), .REFRESH_PERIOD(20), .MODE_REG(13'h020)
    ) dut (
        .clock_50mhz(clk), .pin_reset(rst), .ref_gnt(gnt),
        .init_done(init_done), .ref_req(ref_req), .ref_done(ref_done), .ref_late(ref_late),
        .bus_own(bus_own), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
        .ba(ba), .addr(addr)
    );
    always @(posedge clk or posedge rst)
        if (rst) cyc <= -1;
        else cyc <= cyc + 1;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask
    task automatic push(input int c, input logic d, input logic [3:0] cm, input logic o,
                        input logic [12:0] a, input logic [12:0] m);
        evt_t x;
        x.cyc = c; x.done = d; x.cmd = cm; x.own = o; x.addr = a; x.mask = m;
        sb.push_back(x);
    endtask
    task automatic wait_until(input int n);
        int b = 0;
        @(negedge clk);
        while (cyc != n && b < 300) begin
            @(negedge clk);
            b++;
        end
        if (cyc != n) begin
            checks++;
            fails++;
            $display("FAIL wait_cycle: reached %0d, expected %0d", cyc, n);
        end
    endtask
    task automatic check_reset(input string name);
        check(name, 64'({cke, cs_n, ras_n, cas_n, we_n, ba, addr, init_done, ref_req, ref_done, ref_late, bus_own}),
              64'({1'b0, 4'hF, 2'b00, 13'h0, 4'b0000, 1'b1}));
    endtask
    always @(negedge clk) begin
        if (rst) last_cyc = -1;
        else if (cyc >= 0) begin
            mcmd = {cs_n, ras_n, cas_n, we_n};
            if (bus_own) check("cs_n_owned", 64'(cs_n), 64'(0));
            if (mcmd != NOP || ref_done) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_event at cycle %0d: cmd %b done %b, expected none", cyc, mcmd, ref_done);
                end else begin
                    e = sb.pop_front();
                    check("event", {cyc, 3'b0, ref_done, mcmd, bus_own, addr & e.mask, ba},
                          {e.cyc, 3'b0, e.done, e.cmd, e.own, e.addr & e.mask, 2'b00});
                end
                if (mcmd != NOP) begin
                    if (last_cyc >= 0) begin
                        gap = last_cmd == PREC ? TRP : last_cmd == AREF ? TRFC : TMRD;
                        check("cmd_spacing", 64'(cyc - last_cyc >= gap), 64'(1));
                    end
                    last_cmd = mcmd;
                    last_cyc = cyc;
                end
            end
        end
    end
    initial begin
        rst = 1'b1;
        gnt = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset_values");
        push(10, 0, PREC, 1, 13'h400, 13'h400);
        push(12, 0, AREF, 1, 13'h0, 13'h0);
        rst = 1'b0;
        wait_until(13);
        rst = 1'b1;
        #1 check_reset("async_reset_in_wrfc");
        repeat (2) @(negedge clk);
        push(10, 0, PREC, 1, 13'h400, 13'h400);
        push(12, 0, AREF, 1, 13'h0, 13'h0);
        push(15, 0, AREF, 1, 13'h0, 13'h0);
        push(18, 0, LMOD, 1, 13'h020, 13'h1FFF);
        push(41, 0, AREF, 1, 13'h0, 13'h0);
        push(44, 1, NOP, 0, 13'h0, 13'h0);
        push(61, 0, AREF, 1, 13'h0, 13'h0);
        push(64, 1, NOP, 0, 13'h0, 13'h0);
        push(126, 0, AREF, 1, 13'h0, 13'h0);
        push(129, 1, NOP, 0, 13'h0, 13'h0);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            wait_until(k);
            check("powerup_nop", 64'({cke, cs_n, ras_n, cas_n, we_n, bus_own}), 64'({1'b1, NOP, 1'b1}));
        end
        wait_until(19);
        check("init_done_early", 64'(init_done), 64'(0));
        wait_until(20);
        check("init_done_idle", 64'({init_done, bus_own, cke, cs_n, ras_n, cas_n, we_n}), 64'({3'b101, NOP}));
        wait_until(25);
        gnt = 1'b1;
        wait_until(27);
        gnt = 1'b0;
        check("gnt_without_req", 64'({bus_own, ref_req}), 64'(0));
        wait_until(30);
        gnt = 1'b1;
        wait_until(39);
        check("ref_req_before_wrap", 64'(ref_req), 64'(0));
        wait_until(40);
        check("ref_req_at_wrap", 64'(ref_req), 64'(1));
        wait_until(42);
        check("bus_own_rwait", 64'(bus_own), 64'(1));
        wait_until(65);
        gnt = 1'b0;
        wait_until(79);
        check("ref_req_before_wrap3", 64'(ref_req), 64'(0));
        wait_until(80);
        check("ref_req_at_wrap3", 64'(ref_req), 64'(1));
        wait_until(99);
        check("ref_late_before", 64'(ref_late), 64'(0));
        wait_until(100);
        check("ref_late_set", 64'(ref_late), 64'(1));
        wait_until(124);
        check("req_pending", 64'({ref_req, ref_late, bus_own}), 64'(3'b110));
        wait_until(125);
        gnt = 1'b1;
        wait_until(126);
        gnt = 1'b0;
        wait_until(127);
        gnt = 1'b1;
        wait_until(129);
        gnt = 1'b0;
        wait_until(130);
        check("ref_late_sticky", 64'({ref_late, ref_req, bus_own}), 64'(3'b100));
        wait_until(135);
        check("final_idle", 64'({ref_req, bus_own, init_done}), 64'(3'b001));
        check("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
